xbee_receive: RTL and testbench
===============================

XBEE_RECEIVE -- requirements
Module: xbee_receive

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (50 MHz, 115200 baud).
REQ-002 The block SHALL have port CLOCK, input, 1 bit: the single clock, 50 MHz, rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port I_RX_SERIAL, input, 1 bit: UART line from XBee, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port O_RX_BYTE, output, 8 bits: last correctly framed byte.
REQ-006 The block SHALL have port O_RX_DV, output, 1 bit: one-cycle pulse when O_RX_BYTE updates.
REQ-007 The block SHALL have port O_COLOR, output, 3 bits: last decoded color code (1 = FI, 2 = CT, 3 = CS).
REQ-008 The block SHALL have port O_COLOR_VALID, output, 1 bit: one-cycle pulse when O_COLOR updates.
REQ-009 The block SHALL have port O_NODE_NUM, output, 4 bits: last decoded node number.
REQ-010 The block SHALL have port O_NODE_VALID, output, 1 bit: one-cycle pulse when O_NODE_NUM updates.
REQ-011 The block SHALL have port O_FRAME_ERR, output, 1 bit: one-cycle pulse when a stop bit is sampled low.

Function
REQ-012 The block SHALL pass I_RX_SERIAL through a 2-flop synchronizer; all line decisions SHALL use the synchronized value.
REQ-013 The UART FSM SHALL have states IDLE, START, DATA, STOP and CLEANUP, held in a 3-bit register, with a 9-bit clock counter and a 3-bit bit index.
REQ-014 IDLE: counter and index are 0; a synchronized low SHALL move the FSM to START.
REQ-015 START: at count (CLKS_PER_BIT-1)/2 (= 216) the line SHALL be re-sampled; low SHALL go to DATA with the counter cleared; high SHALL return to IDLE as a glitch, with no outputs.
REQ-016 DATA: each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, stored at the current bit index (LSB first), and the counter cleared; after index 7 is stored, the FSM SHALL go to STOP.
REQ-017 STOP: at count CLKS_PER_BIT-1 a high sample SHALL load O_RX_BYTE and pulse O_RX_DV on the next cycle; a low sample SHALL pulse O_FRAME_ERR instead, with O_RX_BYTE unchanged.
REQ-018 CLEANUP SHALL last one cycle, clear the counter and index, and go to IDLE.
REQ-019 The message parser SHALL consume only O_RX_DV bytes, using a 4-bit position counter and a message-type flag (COLOR or NODE).
REQ-020 A color message SHALL be the ASCII sequence S I - W - X Y - #, where XY is FI, CT or CS; on '#' at position 8, O_COLOR SHALL be set to 1, 2 or 3 and O_COLOR_VALID pulsed one cycle later.
REQ-021 A node message SHALL be the ASCII sequence N O D E d, where d is '0' to '9'; on the digit, O_NODE_NUM SHALL be set to d-0x30 and O_NODE_VALID pulsed one cycle later.
REQ-022 A byte that does not match the expected byte SHALL reset the parser to position 0; if that byte is 'S' or 'N', it SHALL be taken as position 0 of a new message.
REQ-023 An illegal XY pair (anything other than FI, CT, CS) SHALL discard the message.
REQ-024 O_FRAME_ERR SHALL reset the parser to position 0.
REQ-025 O_COLOR and O_NODE_NUM SHALL hold their values until the next valid message of the same type.
REQ-026 At most one of O_COLOR_VALID and O_NODE_VALID SHALL assert in any cycle.

Reset
REQ-027 While RESET_N is low, the FSM and parser SHALL be in IDLE/position 0, and all outputs SHALL be 0, with the line synchronizer flops at 1.
REQ-028 Reset asserted mid-byte or mid-message SHALL abort it without any valid pulse; reception SHALL resume at the next start bit after release.

Verification
REQ-029 Send byte 0x53 at 434 clocks per bit -> O_RX_BYTE = 0x53, one O_RX_DV pulse, about 9.5 bit times after the start edge plus 2 sync cycles.
REQ-030 Send "SI-W-CT-#" -> a single O_COLOR_VALID pulse after '#', with O_COLOR = 2; then send "SI-W-CS-#" -> O_COLOR = 3.
REQ-031 Send "NODE7" -> O_NODE_NUM = 7 with one O_NODE_VALID pulse; then send "SI-W-" followed by "NODE3" -> O_NODE_NUM = 3, no color pulse, O_COLOR unchanged.
REQ-032 Drive a 100-clock low glitch on the line -> no O_RX_DV and no O_FRAME_ERR; FSM back in IDLE.
REQ-033 Send 0x46 with its stop bit held low -> O_FRAME_ERR pulse, no O_RX_DV; an in-progress "SI-W-" is discarded, so a following "FI-#" yields no O_COLOR_VALID.
REQ-034 Assert RESET_N low during bit 4 of a byte -> all outputs 0 and no pulses; the next complete byte after release is received correctly.

Source files
------------

// File: rtl/xbee_receive.sv
// xbee_receive: 8N1 UART receiver for the XBee link, plus a small ASCII
// message parser that extracts color codes ("SI-W-XY-#") and node numbers
// ("NODEd") from the received byte stream.
module xbee_receive #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       I_RX_SERIAL,
  output logic [7:0] O_RX_BYTE,
  output logic       O_RX_DV,
  output logic [2:0] O_COLOR,
  output logic       O_COLOR_VALID,
  output logic [3:0] O_NODE_NUM,
  output logic       O_NODE_VALID,
  output logic       O_FRAME_ERR
);

  localparam logic [8:0] CNT_LAST = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] CNT_MID  = 9'((CLKS_PER_BIT - 1) / 2);

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_O    = 8'h4F;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer (idle-high so reset does not look like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;
  logic rx_meta_d, rx_sync_d;

  // Next value of the two synchronizer stages
  always_comb begin
    rx_meta_d = I_RX_SERIAL;
    rx_sync_d = rx_meta_q;
  end

  // Two-flop synchronizer on the asynchronous serial line
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [8:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic [7:0] rx_byte_q;
  logic       rx_dv_q;
  logic       ferr_q;

  // UART FSM: mid-bit sampling, registered byte/valid/frame-error outputs
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_sync_q) state_q <= S_START;
        end
        S_START: begin
          // Re-check mid start bit; a high line here was only a glitch
          if (cnt_q == CNT_MID) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync_q;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              rx_byte_q <= shift_q;
              rx_dv_q   <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state_q <= S_CLEANUP;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_CLEANUP: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Message parser
  // ---------------------------------------------------------------------------
  logic [3:0] pos_q, pos_d;
  logic       node_msg_q, node_msg_d;   // 0 = color message, 1 = node message
  logic       x_is_f_q, x_is_f_d;       // first letter of the XY pair was 'F'
  logic [1:0] code_q, code_d;           // color code decoded from XY
  logic [2:0] color_q, color_d;
  logic       color_vld_q, color_vld_d;
  logic [3:0] node_q, node_d;
  logic       node_vld_q, node_vld_d;
  logic       match, done;

  // Parser next state: advance on an expected byte, otherwise resync
  always_comb begin
    pos_d       = pos_q;
    node_msg_d  = node_msg_q;
    x_is_f_d    = x_is_f_q;
    code_d      = code_q;
    color_d     = color_q;
    color_vld_d = 1'b0;
    node_d      = node_q;
    node_vld_d  = 1'b0;
    match       = 1'b0;
    done        = 1'b0;
    if (ferr_q) begin
      pos_d = '0;
    end else if (rx_dv_q) begin
      if (pos_q != 4'd0) begin
        if (!node_msg_q) begin
          case (pos_q)
            4'd1:             match = (rx_byte_q == CH_I);
            4'd2, 4'd4, 4'd7: match = (rx_byte_q == CH_DASH);
            4'd3:             match = (rx_byte_q == CH_W);
            4'd5: begin
              match    = (rx_byte_q == CH_F) || (rx_byte_q == CH_C);
              x_is_f_d = (rx_byte_q == CH_F);
            end
            4'd6: begin
              if (x_is_f_q && rx_byte_q == CH_I) begin
                match = 1'b1; code_d = 2'd1;
              end else if (!x_is_f_q && rx_byte_q == CH_T) begin
                match = 1'b1; code_d = 2'd2;
              end else if (!x_is_f_q && rx_byte_q == CH_S) begin
                match = 1'b1; code_d = 2'd3;
              end
            end
            4'd8: begin
              match = (rx_byte_q == CH_HASH);
              done  = match;
              if (match) begin
                color_d     = {1'b0, code_q};
                color_vld_d = 1'b1;
              end
            end
            default: match = 1'b0;
          endcase
        end else begin
          case (pos_q)
            4'd1: match = (rx_byte_q == CH_O);
            4'd2: match = (rx_byte_q == CH_D);
            4'd3: match = (rx_byte_q == CH_E);
            4'd4: begin
              match = (rx_byte_q >= CH_0) && (rx_byte_q <= CH_9);
              done  = match;
              if (match) begin
                node_d     = 4'(rx_byte_q - CH_0);
                node_vld_d = 1'b1;
              end
            end
            default: match = 1'b0;
          endcase
        end
      end
      if (done) begin
        pos_d = '0;
      end else if (match) begin
        pos_d = pos_q + 4'd1;
      end else if (rx_byte_q == CH_S) begin
        pos_d      = 4'd1;
        node_msg_d = 1'b0;
      end else if (rx_byte_q == CH_N) begin
        pos_d      = 4'd1;
        node_msg_d = 1'b1;
      end else begin
        pos_d = '0;
      end
    end
  end

  // Parser state and decoded outputs
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pos_q       <= '0;
      node_msg_q  <= 1'b0;
      x_is_f_q    <= 1'b0;
      code_q      <= '0;
      color_q     <= '0;
      color_vld_q <= 1'b0;
      node_q      <= '0;
      node_vld_q  <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      node_msg_q  <= node_msg_d;
      x_is_f_q    <= x_is_f_d;
      code_q      <= code_d;
      color_q     <= color_d;
      color_vld_q <= color_vld_d;
      node_q      <= node_d;
      node_vld_q  <= node_vld_d;
    end
  end

  assign O_RX_BYTE     = rx_byte_q;
  assign O_RX_DV       = rx_dv_q;
  assign O_FRAME_ERR   = ferr_q;
  assign O_COLOR       = color_q;
  assign O_COLOR_VALID = color_vld_q;
  assign O_NODE_NUM    = node_q;
  assign O_NODE_VALID  = node_vld_q;

endmodule

// File: tb/tb_xbee_receive.sv
// Directed bench for xbee_receive: a UART driver feeds bytes/messages and
// pushes expected bytes, colors, nodes and frame errors into queues; a
// negedge monitor pops and compares whenever the DUT pulses a valid.
module tb_xbee_receive;
  localparam int CLKS = 64;
  localparam int GLITCH = 20;   // well under half a bit, like 100 of 434

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       I_RX_SERIAL = 1'b1;
  logic [7:0] O_RX_BYTE;
  logic       O_RX_DV;
  logic [2:0] O_COLOR;
  logic       O_COLOR_VALID;
  logic [3:0] O_NODE_NUM;
  logic       O_NODE_VALID;
  logic       O_FRAME_ERR;

  xbee_receive #(.CLKS_PER_BIT(CLKS)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .I_RX_SERIAL(I_RX_SERIAL),
    .O_RX_BYTE(O_RX_BYTE), .O_RX_DV(O_RX_DV),
    .O_COLOR(O_COLOR), .O_COLOR_VALID(O_COLOR_VALID),
    .O_NODE_NUM(O_NODE_NUM), .O_NODE_VALID(O_NODE_VALID),
    .O_FRAME_ERR(O_FRAME_ERR)
  );

  always #10 CLOCK = ~CLOCK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_ferr = 0;
  bit lat_armed = 1'b0;
  logic [7:0] exp_bytes[$];
  logic [2:0] exp_colors[$];
  logic [3:0] exp_nodes[$];

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (O_RX_DV) begin
        total++;
        assert (exp_bytes.size() != 0) else begin
          bad++; $error("FAIL rx_dv_unexpected: got byte %02h want no pulse", O_RX_BYTE);
        end
        if (exp_bytes.size() != 0) begin
          logic [7:0] eb;
          eb = exp_bytes.pop_front();
          total++;
          assert (O_RX_BYTE === eb) else begin
            bad++; $error("FAIL rx_byte: got %02h want %02h", O_RX_BYTE, eb);
          end
        end
        if (lat_armed) begin
          lat_armed = 1'b0;
          total++;
          assert ((cyc - start_cyc) >= (CLKS*19/2 - 6) && (cyc - start_cyc) <= (CLKS*19/2 + 8)) else begin
            bad++; $error("FAIL rx_latency: got %0d cycles want about %0d", cyc - start_cyc, CLKS*19/2);
          end
        end
      end
      if (O_COLOR_VALID) begin
        total++;
        assert (exp_colors.size() != 0) else begin
          bad++; $error("FAIL color_unexpected: got color %0d want no pulse", O_COLOR);
        end
        if (exp_colors.size() != 0) begin
          logic [2:0] ec;
          ec = exp_colors.pop_front();
          total++;
          assert (O_COLOR === ec) else begin
            bad++; $error("FAIL color: got %0d want %0d", O_COLOR, ec);
          end
        end
      end
      if (O_NODE_VALID) begin
        total++;
        assert (exp_nodes.size() != 0) else begin
          bad++; $error("FAIL node_unexpected: got node %0d want no pulse", O_NODE_NUM);
        end
        if (exp_nodes.size() != 0) begin
          logic [3:0] en;
          en = exp_nodes.pop_front();
          total++;
          assert (O_NODE_NUM === en) else begin
            bad++; $error("FAIL node: got %0d want %0d", O_NODE_NUM, en);
          end
        end
      end
      if (O_COLOR_VALID || O_NODE_VALID) begin
        total++;
        assert (!(O_COLOR_VALID && O_NODE_VALID)) else begin
          bad++; $error("FAIL valid_exclusive: got both valids want at most one");
        end
      end
      if (O_FRAME_ERR) begin
        total++;
        assert (exp_ferr > 0) else begin
          bad++; $error("FAIL frame_err_unexpected: got pulse want none");
        end
        if (exp_ferr > 0) exp_ferr--;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame starting on a falling edge, then one idle bit
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge CLOCK);
    for (int i = 0; i < 10; i++) begin
      I_RX_SERIAL = frame[i];
      if (i == 0) start_cyc = cyc;
      repeat (CLKS) @(negedge CLOCK);
    end
    I_RX_SERIAL = 1'b1;
    repeat (CLKS) @(negedge CLOCK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      exp_bytes.push_back(s[i]);
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte"},  32'(O_RX_BYTE), 32'h0);
    check({tag, "_pulses"}, {28'h0, O_RX_DV, O_COLOR_VALID, O_NODE_VALID, O_FRAME_ERR}, 32'h0);
    check({tag, "_color"}, 32'(O_COLOR), 32'h0);
    check({tag, "_node"},  32'(O_NODE_NUM), 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge CLOCK);
    check_all_zero("reset");
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK);

    // Single byte with latency check
    exp_bytes.push_back(8'h53);
    lat_armed = 1'b1;
    send_byte(8'h53, 1'b1);
    check("byte_53_held", 32'(O_RX_BYTE), 32'h53);

    // Color messages
    exp_colors.push_back(3'd2);
    send_str("SI-W-CT-#");
    check("color_ct", 32'(O_COLOR), 32'd2);
    exp_colors.push_back(3'd3);
    send_str("SI-W-CS-#");
    check("color_cs", 32'(O_COLOR), 32'd3);

    // Node messages, including an interrupted color message
    exp_nodes.push_back(4'd7);
    send_str("NODE7");
    check("node_7", 32'(O_NODE_NUM), 32'd7);
    exp_nodes.push_back(4'd3);
    send_str("SI-W-NODE3");
    check("node_3", 32'(O_NODE_NUM), 32'd3);
    check("color_hold", 32'(O_COLOR), 32'd3);

    // Illegal XY pair is discarded
    send_str("SI-W-FT-#");
    check("color_illegal_hold", 32'(O_COLOR), 32'd3);

    // Short low glitch, then a clean byte
    @(negedge CLOCK);
    I_RX_SERIAL = 1'b0;
    repeat (GLITCH) @(negedge CLOCK);
    I_RX_SERIAL = 1'b1;
    repeat (2*CLKS) @(negedge CLOCK);
    exp_bytes.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    check("after_glitch", 32'(O_RX_BYTE), 32'h5A);

    // Framing error aborts an in-progress color message
    send_str("SI-W-");
    exp_ferr++;
    send_byte(8'h46, 1'b0);
    check("ferr_byte_hold", 32'(O_RX_BYTE), 32'h2D);
    send_str("I-#");
    check("ferr_no_color", 32'(O_COLOR), 32'd3);

    // Reset in the middle of bit 4, held until the aborted frame is over
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (CLKS*5 + CLKS/2) @(negedge CLOCK);
        RESET_N = 1'b0;
      end
    join
    check_all_zero("midreset");
    RESET_N = 1'b1;
    repeat (CLKS) @(negedge CLOCK);
    exp_bytes.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    check("post_reset_byte", 32'(O_RX_BYTE), 32'h3C);
    exp_nodes.push_back(4'd9);
    send_str("NODE9");
    check("post_reset_node", 32'(O_NODE_NUM), 32'd9);

    // Everything expected must have arrived
    repeat (CLKS) @(negedge CLOCK);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("colors_left", 32'(exp_colors.size()), 32'd0);
    check("nodes_left", 32'(exp_nodes.size()), 32'd0);
    check("ferr_left", 32'(exp_ferr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
